piso_serializer: RTL and testbench

Parallel-in serial-out transmitter: accepts a WIDTH-bit word via valid/ready handshake and shifts it out one bit per enable strobe, LSB first. This is the transmit end of the in-fabric serial sample link (e.g. voice/sample words to a DAC or to a downstream SIPO receiver). Bit k is valid on `out` during the cycle of the k-th enable strobe, so a receiver sampling on that same edge reconstructs the word.

---
 rtl/piso_pkg.sv | 10 +
 rtl/piso_serializer.sv | 133 +++++++++++++
 tb/tb_piso_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types for the parallel-in serial-out transmitter
package piso_pkg;

    // IDLE: line quiet, waiting for a word. SHIFT: a word is on the line.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - WIDTH-bit parallel-in serial-out transmitter, LSB first
//
// Accepts a word on a valid/ready handshake and places one bit per enable
// strobe on `out`, bit 0 first. Bit k is on the line during the cycle of the
// k-th strobe so a receiver sampling on that same edge rebuilds the word.
//
// Optional feature macro: PISO_DOUBLE_BUFFER_EN
//   defined   - adds a one-word holding register so words stream gaplessly
//   undefined - one word at a time, at least one IDLE cycle between words
//
// Ports:
//   clk         system clock
//   rstn        asynchronous active-low reset
//   enable      bit strobe; one bit consumed per cycle with enable high
//   data_in     parallel word to transmit
//   load_valid  data_in valid
//   load_ready  block can accept a word this cycle
//   out         serial data, LSB first
//   busy        high while a word is on the line
//   word_start  high while bit 0 is on the line
//   word_done   single-cycle pulse on the strobe that consumes the last bit
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             busy,
    output logic             word_start,
    output logic             word_done
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;

    logic load_fire;
    logic last_bit;

    assign load_fire  = load_valid && load_ready;
    assign last_bit   = (state == SHIFT) && enable && (count == LAST);

    // shreg is cleared on every return to IDLE, so gating with state only
    // makes the quiet-line value explicit.
    assign out        = (state == SHIFT) && shreg[0];
    assign busy       = (state == SHIFT);
    assign word_start = (state == SHIFT) && (count == '0);
    assign word_done  = last_bit;

`ifdef PISO_DOUBLE_BUFFER_EN
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    // Gated with rstn so the source never sees ready while reset is held.
    assign load_ready = rstn && !hold_full;

    // A word accepted during SHIFT parks in hold, except on the last-bit
    // strobe with hold empty: that one goes straight into shreg.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if ((state == SHIFT) && load_fire && !last_bit) begin
            hold      <= data_in;
            hold_full <= 1'b1;
        end else if (last_bit && hold_full) begin
            hold_full <= 1'b0;
        end
    end
`else
    assign load_ready = rstn && (state == IDLE);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            shreg <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Load wins over a coincident enable: no shift this cycle.
                    if (load_fire) begin
                        shreg <= data_in;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        if (count == LAST) begin
`ifdef PISO_DOUBLE_BUFFER_EN
                            if (hold_full) begin
                                shreg <= hold;
                                count <= '0;
                            end else if (load_fire) begin
                                shreg <= data_in;
                                count <= '0;
                            end else begin
                                shreg <= '0;
                                count <= '0;
                                state <= IDLE;
                            end
`else
                            shreg <= '0;
                            count <= '0;
                            state <= IDLE;
`endif
                        end else begin
                            shreg <= shreg >> 1;
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    shreg <= '0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard testbench for piso_serializer (WIDTH=8)
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         enable = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load_ready;
    logic         out;
    logic         busy;
    logic         word_start;
    logic         word_done;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .out        (out),
        .busy       (busy),
        .word_start (word_start),
        .word_done  (word_done)
    );

    typedef struct packed {
        logic b;
        logic ws;
        logic wd;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line contents for one word: LSB first, start on bit 0, done on bit W-1.
    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b  = w[i];
            e.ws = (i == 0);
            e.wd = (i == W - 1);
            expq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_strobes(input int n);
        enable = 1'b1;
        repeat (n) tick();
        enable = 1'b0;
    endtask

    task automatic load_word(input logic [W-1:0] w, input logic en);
        int t;
        t = 0;
        while (!load_ready && t < 100) begin
            tick();
            t++;
        end
        chk("load_ready_wait", load_ready, 1);
        data_in    = w;
        load_valid = 1'b1;
        enable     = en;
        tick();
        load_valid = 1'b0;
        enable     = 1'b0;
        push_word(w);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_out"}, out, 0);
        chk({name, "_ready"}, load_ready, 1);
    endtask

    // Monitor: every cycle with a bit on the line and a strobe consumes one
    // expected entry; anywhere else word_done must stay low.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (busy && enable) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_bit", expq.size(), 1);
                    end else begin
                        mon_e = expq.pop_front();
                        chk("out", out, mon_e.b);
                        chk("word_start", word_start, mon_e.ws);
                        chk("word_done", word_done, mon_e.wd);
                    end
                end else begin
                    chk("word_done_quiet", word_done, 0);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] w2;
        logic [W-1:0] dbw [3];
        logic         lr;
        logic         vld;
        int           si;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_word_start", word_start, 0);
        chk("rst_word_done", word_done, 0);
        rstn = 1'b1;
        tick();
        chk_idle("post_rst");

        // 0xA5, continuous enable
        load_word(8'hA5, 1'b0);
        chk("a5_busy", busy, 1);
        chk("a5_out0", out, 1);
        run_strobes(W);
        chk_idle("a5_end");

        // 0x3C, strobe every third cycle; line holds between strobes
        w2 = 8'h3C;
        load_word(w2, 1'b0);
        for (int k = 0; k < W; k++) begin
            enable = 1'b1;
            tick();
            enable = 1'b0;
            if (k < W - 1) begin
                repeat (2) begin
                    chk("3c_hold_out", out, w2[k+1]);
                    chk("3c_hold_busy", busy, 1);
                    tick();
                end
            end
        end
        chk_idle("3c_end");

`ifndef PISO_DOUBLE_BUFFER_EN
        // load_valid held high with two words: one idle cycle between them
        data_in    = 8'hFF;
        load_valid = 1'b1;
        tick();
        push_word(8'hFF);
        data_in = 8'h01;
        enable  = 1'b1;
        for (int i = 0; i < W; i++) begin
            chk("ff_ready_in_shift", load_ready, 0);
            tick();
        end
        chk_idle("gap");
        push_word(8'h01);
        tick();
        load_valid = 1'b0;
        chk("gap_one_cycle", busy, 1);
        repeat (W) tick();
        enable = 1'b0;
        chk_idle("q01_end");
`else
        // Back-to-back words through the holding register, no gap
        dbw[0] = 8'hAA;
        dbw[1] = 8'h55;
        dbw[2] = 8'hF0;
        data_in    = dbw[0];
        load_valid = 1'b1;
        tick();
        push_word(dbw[0]);
        si      = 1;
        data_in = dbw[1];
        enable  = 1'b1;
        for (int cyc = 0; cyc < 3 * W; cyc++) begin
            lr  = load_ready;
            vld = load_valid;
            tick();
            if (vld && lr) begin
                push_word(dbw[si]);
                si++;
                if (si < 3) data_in = dbw[si];
                else load_valid = 1'b0;
            end
            if (cyc == 0) chk("db_hold_full_ready", load_ready, 0);
            if (cyc < 3 * W - 1) chk("db_gapless_busy", busy, 1);
        end
        enable = 1'b0;
        chk("db_all_accepted", si, 3);
        chk_idle("db_end");
`endif

        // Async reset at bit 4 of 0xFF
        load_word(8'hFF, 1'b0);
        enable = 1'b1;
        repeat (4) tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out", out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", load_ready, 0);
        chk("arst_word_done", word_done, 0);
        enable = 1'b0;
        expq.delete();
        tick();
        rstn = 1'b1;
        tick();
        load_word(8'h81, 1'b0);
        run_strobes(W);
        chk_idle("81_end");

        // Load and enable together in IDLE: no shift on the load edge
        load_word(8'h01, 1'b1);
        chk("le_busy", busy, 1);
        chk("le_out", out, 1);
        chk("le_word_start", word_start, 1);
        run_strobes(W);
        chk_idle("le_end");

        tick();
        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
